// File: rtl/ucsbece154b_perfmon_pkg.sv
// Shared constants, FSM encoding and small helpers for the dual-issue performance monitor.
package ucsbece154b_perfmon_pkg;

  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Both all-zero (bubble) and canonical addi x0,x0,0 are treated as non-instructions.
  function automatic logic is_real_instr(input logic [31:0] instr);
    return (instr != 32'h0) && (instr != NOP_INSTR);
  endfunction

  function automatic logic [1:0] count2(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/ucsbece154b_perfmon_if.sv
// Pipeline tap bundle: both slots of fetch, decode and execute as seen by the monitor.
// The pipeline drives every signal (master); the monitor only observes (slave). No handshake.
interface ucsbece154b_perfmon_if;
  logic [31:0] PCF_i, PCF2_i;
  logic [31:0] InstrF_i, InstrF2_i;
  logic [31:0] InstrD_i, InstrD2_i;
  logic [6:0]  opE_i, opE2_i;
  logic        Mispredict_i, Mispredict2_i;
  logic        BranchTakenF_i, BranchTakenF2_i;

  modport master (
    output PCF_i, PCF2_i, InstrF_i, InstrF2_i, InstrD_i, InstrD2_i,
           opE_i, opE2_i, Mispredict_i, Mispredict2_i, BranchTakenF_i, BranchTakenF2_i
  );

  modport slave (
    input PCF_i, PCF2_i, InstrF_i, InstrF2_i, InstrD_i, InstrD2_i,
          opE_i, opE2_i, Mispredict_i, Mispredict2_i, BranchTakenF_i, BranchTakenF2_i
  );
endinterface

// File: rtl/ucsbece154b_perfmon_halt_det.sv
// End-of-program detector: both fetch slots parked on a NOP at the same PC as last RUN cycle.
module ucsbece154b_perfmon_halt_det
  import ucsbece154b_perfmon_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        run_i,
  input  logic [31:0] pc1_i,
  input  logic [31:0] pc2_i,
  input  logic [31:0] instr1_i,
  input  logic [31:0] instr2_i,
  output logic        halt_o
);

  logic [31:0] prev_pc1_q, prev_pc1_d;
  logic [31:0] prev_pc2_q, prev_pc2_d;

  always_comb begin
    prev_pc1_d = prev_pc1_q;
    prev_pc2_d = prev_pc2_q;
    if (clear_i) begin
      prev_pc1_d = '0;
      prev_pc2_d = '0;
    end else if (run_i) begin
      prev_pc1_d = pc1_i;
      prev_pc2_d = pc2_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_pc1_q <= '0;
      prev_pc2_q <= '0;
    end else begin
      prev_pc1_q <= prev_pc1_d;
      prev_pc2_q <= prev_pc2_d;
    end
  end

  assign halt_o = run_i
               && (pc1_i == prev_pc1_q) && (instr1_i == NOP_INSTR)
               && (pc2_i == prev_pc2_q) && (instr2_i == NOP_INSTR);

endmodule

// File: rtl/ucsbece154b_perfmon.sv
// Dual-issue performance monitor with halt/timeout detection; counters saturate and freeze in DONE.
// Jump counters exist only when PERFMON_JUMP_EN is defined; otherwise they read as zero.
module ucsbece154b_perfmon
  import ucsbece154b_perfmon_pkg::*;
#(
  parameter int CNT_WIDTH  = 32,
  parameter int MAX_CYCLES = 500
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable_i,
  input  logic                 clear_i,
  ucsbece154b_perfmon_if.slave tap,
  output logic [CNT_WIDTH-1:0] cycle_count_o,
  output logic [CNT_WIDTH-1:0] instr_count_o,
  output logic [CNT_WIDTH-1:0] branch_count_o,
  output logic [CNT_WIDTH-1:0] branch_miss_o,
  output logic [CNT_WIDTH-1:0] jump_count_o,
  output logic [CNT_WIDTH-1:0] jump_miss_o,
  output logic                 running_o,
  output logic                 done_o,
  output logic                 timeout_o,
  output state_e               state_o
);

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [1:0] inc);
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, a} + {{(CNT_WIDTH-1){1'b0}}, inc};
    return sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
  endfunction

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cycle_count_q, cycle_count_d;
  logic [CNT_WIDTH-1:0] instr_count_q, instr_count_d;
  logic [CNT_WIDTH-1:0] branch_count_q, branch_count_d;
  logic [CNT_WIDTH-1:0] branch_miss_q, branch_miss_d;
  logic                 timeout_q, timeout_d;
  logic                 count_en, halt, at_limit, br1, br2;

  assign count_en = (state_q == RUN);
  assign br1      = (tap.opE_i  == OP_BRANCH);
  assign br2      = (tap.opE2_i == OP_BRANCH);
  // Widened compare so a narrow counter can never alias a large cycle limit.
  assign at_limit = (64'(cycle_count_q) == 64'(MAX_CYCLES - 1));

  ucsbece154b_perfmon_halt_det u_halt_det (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (clear_i),
    .run_i    (count_en),
    .pc1_i    (tap.PCF_i),
    .pc2_i    (tap.PCF2_i),
    .instr1_i (tap.InstrF_i),
    .instr2_i (tap.InstrF2_i),
    .halt_o   (halt)
  );

  always_comb begin
    state_d        = state_q;
    cycle_count_d  = cycle_count_q;
    instr_count_d  = instr_count_q;
    branch_count_d = branch_count_q;
    branch_miss_d  = branch_miss_q;
    timeout_d      = timeout_q;
    case (state_q)
      IDLE: if (enable_i) state_d = RUN;
      RUN: begin
        cycle_count_d  = sat_add(cycle_count_q, 2'd1);
        instr_count_d  = sat_add(instr_count_q,
                           count2(is_real_instr(tap.InstrD_i), is_real_instr(tap.InstrD2_i)));
        branch_count_d = sat_add(branch_count_q, count2(br1, br2));
        branch_miss_d  = sat_add(branch_miss_q,
                           count2(br1 && tap.Mispredict_i, br2 && tap.Mispredict2_i));
        // A genuine halt takes precedence over a coincident timeout.
        if (halt) begin
          state_d   = DONE;
          timeout_d = 1'b0;
        end else if (at_limit) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d        = IDLE;
      cycle_count_d  = '0;
      instr_count_d  = '0;
      branch_count_d = '0;
      branch_miss_d  = '0;
      timeout_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cycle_count_q  <= '0;
      instr_count_q  <= '0;
      branch_count_q <= '0;
      branch_miss_q  <= '0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cycle_count_q  <= cycle_count_d;
      instr_count_q  <= instr_count_d;
      branch_count_q <= branch_count_d;
      branch_miss_q  <= branch_miss_d;
      timeout_q      <= timeout_d;
    end
  end

`ifdef PERFMON_JUMP_EN
  logic [CNT_WIDTH-1:0] jump_count_q, jump_count_d;
  logic [CNT_WIDTH-1:0] jump_miss_q, jump_miss_d;
  logic                 jmp1, jmp2;

  assign jmp1 = (tap.opE_i  == OP_JAL) || (tap.opE_i  == OP_JALR);
  assign jmp2 = (tap.opE2_i == OP_JAL) || (tap.opE2_i == OP_JALR);

  // A jump that fetch did not predict taken counts as a miss.
  always_comb begin
    jump_count_d = jump_count_q;
    jump_miss_d  = jump_miss_q;
    if (clear_i) begin
      jump_count_d = '0;
      jump_miss_d  = '0;
    end else if (count_en) begin
      jump_count_d = sat_add(jump_count_q, count2(jmp1, jmp2));
      jump_miss_d  = sat_add(jump_miss_q,
                       count2(jmp1 && !tap.BranchTakenF_i, jmp2 && !tap.BranchTakenF2_i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      jump_count_q <= '0;
      jump_miss_q  <= '0;
    end else begin
      jump_count_q <= jump_count_d;
      jump_miss_q  <= jump_miss_d;
    end
  end

  assign jump_count_o = jump_count_q;
  assign jump_miss_o  = jump_miss_q;
`else
  logic unused_jump;
  assign unused_jump  = ^{tap.BranchTakenF_i, tap.BranchTakenF2_i};
  assign jump_count_o = '0;
  assign jump_miss_o  = '0;
`endif

  assign cycle_count_o  = cycle_count_q;
  assign instr_count_o  = instr_count_q;
  assign branch_count_o = branch_count_q;
  assign branch_miss_o  = branch_miss_q;
  assign timeout_o      = timeout_q;
  assign running_o      = (state_q == RUN);
  assign done_o         = (state_q == DONE);
  assign state_o        = state_q;

endmodule
